// File: rtl/pipeline_pkg.sv
// pipeline_pkg: shared pipeline-control types and constants
package pipeline_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_ERROR    = 2'd2
  } state_t;
  localparam logic [31:0] NOP_INSN = 32'h00000013;
endpackage

// File: rtl/hazard_stall_controller_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, with sync clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);
  always_ff @(posedge clk or posedge reset)
    if (reset) count <= '0;
    else if (clear) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller: load-use stall, branch flush and memory-wait freeze sequencing
module hazard_stall_controller
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_write,
  output logic             mem_wb_bubble,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);
  localparam int TW = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [TW-1:0] LIMIT = TW'(MEM_TIMEOUT - 1);
  state_t state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic err_nx, freeze, load_use, act, fz, br, lu;
  assign load_use = id_ex_mem_read && id_ex_rd != 5'd0 &&
                    (id_ex_rd == id_rs1 || (id_uses_rs2 && id_ex_rd == id_rs2));
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= ST_RUN;
      tcnt      <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nx;
      tcnt      <= tcnt_nx;
      mem_error <= mem_error | err_nx;
    end
  always_comb begin
    state_nx = state;
    tcnt_nx  = tcnt;
    err_nx   = 1'b0;
    freeze   = 1'b0;
    if (state == ST_RUN) begin
      if (mem_req && !mem_ready) begin
        freeze   = 1'b1;
        state_nx = ST_MEM_WAIT;
        tcnt_nx  = TW'(1);
      end
    end else if (state == ST_MEM_WAIT) begin
      if (mem_ready) begin
        state_nx = ST_RUN;
        tcnt_nx  = '0;
      end else begin
        freeze  = 1'b1;
        tcnt_nx = tcnt + 1'b1;
        if (tcnt_nx >= LIMIT) begin
          err_nx   = 1'b1;
          state_nx = ST_ERROR;
        end
      end
    end else begin
      freeze = 1'b1;
    end
  end
  // reset forces the enables high immediately, independent of state and inputs
  assign fz            = !reset && freeze;
  assign act           = !reset && !freeze;
  assign br            = act && branch_taken;
  assign lu            = act && !branch_taken && load_use;
  assign pc_write      = !fz && !lu;
  assign if_id_write   = !fz && !lu;
  assign if_id_flush   = br;
  assign id_ex_bubble  = br || lu;
  assign ex_mem_write  = !fz;
  assign mem_wb_bubble = fz;
  sat_counter #(.W(CNT_W)) u_stall (
    .clk(clk), .reset(reset), .inc(!pc_write), .clear(1'b0), .count(stall_cycles)
  );
  sat_counter #(.W(CNT_W)) u_flush (
    .clk(clk), .reset(reset), .inc(br), .clear(1'b0), .count(flush_count)
  );
endmodule

// File: tb/tb_hazard_stall_controller.sv
// tb_hazard_stall_controller: directed and random checks of two controller instances against a behavioural model
module tb_hazard_stall_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic ld, u2, br, req, rdy;
  logic [4:0] rd, rs1, rs2;
  logic [5:0] a_o, b_o;
  logic a_err, b_err;
  logic [31:0] a_stall, a_flush;
  logic [3:0] b_stall, b_flush;
  int checks = 0, errors = 0;
  int k[2];
  bit err[2];
  longint stall[2], flush[2];
  always #5 clk = ~clk;
  hazard_stall_controller #(.MEM_TIMEOUT(8), .CNT_W(32)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(u2),
    .id_ex_mem_read(ld), .id_ex_rd(rd), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
    .pc_write(a_o[5]), .if_id_write(a_o[4]), .if_id_flush(a_o[3]), .id_ex_bubble(a_o[2]),
    .ex_mem_write(a_o[1]), .mem_wb_bubble(a_o[0]), .mem_error(a_err),
    .stall_cycles(a_stall), .flush_count(a_flush)
  );
  hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(rs1), .id_rs2(rs2), .id_uses_rs2(u2),
    .id_ex_mem_read(ld), .id_ex_rd(rd), .branch_taken(br), .mem_req(req), .mem_ready(rdy),
    .pc_write(b_o[5]), .if_id_write(b_o[4]), .if_id_flush(b_o[3]), .id_ex_bubble(b_o[2]),
    .ex_mem_write(b_o[1]), .mem_wb_bubble(b_o[0]), .mem_error(b_err),
    .stall_cycles(b_stall), .flush_count(b_flush)
  );
  function automatic int mt(int i);
    return i != 0 ? 4 : 8;
  endfunction
  function automatic longint cmax(int i);
    return i != 0 ? 64'd15 : 64'hFFFF_FFFF;
  endfunction
  // expected {pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_mem_write, mem_wb_bubble}
  function automatic logic [5:0] ref_out(int i);
    logic hz;
    hz = ld && rd != 0 && (rd == rs1 || (u2 && rd == rs2));
    if (reset) return 6'b110010;
    if (err[i] || (k[i] > 0 && !rdy) || (k[i] == 0 && req && !rdy)) return 6'b000001;
    if (br) return 6'b111110;
    if (hz) return 6'b000110;
    return 6'b110010;
  endfunction
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic compare();
    check("out_a", 64'(a_o), 64'(ref_out(0)));
    check("out_b", 64'(b_o), 64'(ref_out(1)));
    check("err_a", 64'(a_err), 64'(err[0]));
    check("err_b", 64'(b_err), 64'(err[1]));
    check("stall_a", 64'(a_stall), 64'(stall[0]));
    check("stall_b", 64'(b_stall), 64'(stall[1]));
    check("flush_a", 64'(a_flush), 64'(flush[0]));
    check("flush_b", 64'(b_flush), 64'(flush[1]));
  endtask
  task automatic model_tick();
    for (int i = 0; i < 2; i++) begin
      logic [5:0] o;
      o = ref_out(i);
      if (!o[5] && stall[i] < cmax(i)) stall[i]++;
      if (o == 6'b111110 && flush[i] < cmax(i)) flush[i]++;
      if (!err[i]) begin
        if (k[i] == 0) k[i] = (req && !rdy) ? 1 : 0;
        else if (rdy) k[i] = 0;
        else begin
          k[i]++;
          if (k[i] >= mt(i) - 1) err[i] = 1'b1;
        end
      end
    end
  endtask
  task automatic step();
    @(negedge clk);
    compare();
    model_tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_in(logic l, logic [4:0] d, logic [4:0] s1, logic [4:0] s2,
                        logic u, logic b, logic q, logic y);
    ld = l; rd = d; rs1 = s1; rs2 = s2; u2 = u; br = b; req = q; rdy = y;
  endtask
  // asserts reset between edges and checks the immediate effect
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; err[i] = 1'b0; stall[i] = 0; flush[i] = 0;
    end
    check("rst_out_a", 64'(a_o), 64'b110010);
    check("rst_out_b", 64'(b_o), 64'b110010);
    check("rst_cnt", 64'({a_stall, a_flush, b_stall, b_flush, a_err, b_err}), 64'd0);
    compare();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask
  initial begin
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; err[i] = 1'b0; stall[i] = 0; flush[i] = 0;
    end
    #2;
    check("init_out", 64'(a_o), 64'b110010);
    compare();
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // load-use: single stall cycle
    do_reset();
    set_in(1, 5, 5, 0, 0, 0, 0, 0);
    #1 check("t1_stall", 64'(a_o), 64'b000110);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t1_free", 64'(a_o), 64'b110010);
    check("t1_cnt", 64'(a_stall), 64'd1);
    step();
    // x0 destination and unused rs2 never stall
    do_reset();
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t2_x0", 64'(a_o), 64'b110010);
    step();
    set_in(1, 7, 1, 7, 0, 0, 0, 0);
    #1 check("t2_rs2", 64'(a_o), 64'b110010);
    step();
    check("t2_cnt", 64'(a_stall), 64'd0);
    // branch wins over load-use
    do_reset();
    set_in(1, 5, 5, 0, 0, 1, 0, 0);
    #1 check("t3_flush", 64'(a_o), 64'b111110);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t3_cnt", 64'(a_flush), 64'd1);
    step();
    // three-cycle memory wait then release
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    repeat (3) begin
      #1 check("t4_frz", 64'(a_o), 64'b000001);
      step();
    end
    set_in(0, 0, 0, 0, 0, 0, 1, 1);
    #1 check("t4_rel", 64'(a_o), 64'b110010);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    #1 check("t4_cnt", 64'(a_stall), 64'd3);
    step();
    // timeout on the short-timeout instance
    do_reset();
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 6; c++) begin
      #1 check("t5_err", 64'(b_err), 64'(c >= 4));
      check("t5_frz", 64'(b_o), 64'b000001);
      step();
    end
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    #1 check("t5_stuck", 64'(b_o), 64'b000001);
    check("t5_sticky", 64'(b_err), 64'd1);
    step();
    do_reset();
    check("t5_clr", 64'(b_err), 64'd0);
    // saturate the narrow counter, then reset during a memory wait
    set_in(1, 5, 5, 0, 0, 0, 0, 0);
    repeat (17) step();
    check("t6_sat", 64'(b_stall), 64'd15);
    set_in(0, 0, 0, 0, 0, 0, 1, 0);
    step();
    step();
    check("t6_hold", 64'(b_stall), 64'd15);
    do_reset();
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 149) == 0) do_reset();
      else begin
        set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
               5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
        step();
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
